counter_access_ctrl: RTL and testbench

- Controller for the shared 32-bit count register in the user project.
- Arbitrates count loads between the Wishbone slave port and a logic-analyzer load requester.
- Generates a prescaled increment enable and a wrap interrupt.
- Counter flop itself lives outside this block; this block drives its load/enable controls and reads back its value.

---
 rtl/counter_access_ctrl.sv | 158 +++++++++++++++
 tb/tb_counter_access_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_access_ctrl.sv
// Load/enable controller for the shared 32-bit count register: arbitrates Wishbone
// and logic-analyzer loads, prescales the increment enable and flags counter wrap.
module counter_access_ctrl #(
  parameter int unsigned BITS      = 32,
  parameter logic [27:0] ADDR_BASE = 28'h3000000,
  parameter int unsigned PRE_W     = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic            la_req_i,
  input  logic [BITS-1:0] la_data_i,
  input  logic [BITS-1:0] la_mask_i,
  output logic            la_ack_o,
  input  logic [BITS-1:0] cnt_value_i,
  output logic            cnt_load_o,
  output logic [BITS-1:0] cnt_load_data_o,
  output logic [BITS-1:0] cnt_load_mask_o,
  output logic            cnt_en_o,
  output logic            irq_o
);

  typedef enum logic [1:0] {IDLE, WB_DONE, LA_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_last_la;
  logic              r_run, r_irq_en, r_wrap;
  logic [PRE_W-1:0]  r_prescale, r_pcnt;

  logic              w_hit, w_wb_pend, w_la_pend, w_grant_wb, w_grant_la;
  logic [1:0]        w_idx;
  logic              w_wr_count, w_wr_ctrl, w_wr_pre;
  logic [31:0]       w_rd_data, w_sel_mask;
  logic              w_tick, w_wrap_set, w_wrap_clr;
  logic              w_ack_nxt, w_la_ack_nxt, w_load_nxt;
  logic [31:0]       w_dat_nxt;
  logic [BITS-1:0]   w_ld_data_nxt, w_ld_mask_nxt;
  logic              w_unused;

  assign w_unused  = ^wbs_adr_i[1:0];
  assign w_hit     = (wbs_adr_i[31:4] == ADDR_BASE);
  assign w_idx     = wbs_adr_i[3:2];
  assign w_wb_pend = wbs_cyc_i & wbs_stb_i & w_hit;
  assign w_la_pend = la_req_i;

  // On a tie the requester that was not granted last time wins.
  assign w_grant_wb = (r_state == IDLE) & w_wb_pend & (~w_la_pend | r_last_la);
  assign w_grant_la = (r_state == IDLE) & w_la_pend & (~w_wb_pend | ~r_last_la);

  assign w_wr_count = w_grant_wb & wbs_we_i & (w_idx == 2'd0);
  assign w_wr_ctrl  = w_grant_wb & wbs_we_i & (w_idx == 2'd1);
  assign w_wr_pre   = w_grant_wb & wbs_we_i & (w_idx == 2'd2);

  always_comb begin
    w_rd_data = '0;
    unique case (w_idx)
      2'd0: w_rd_data = cnt_value_i;
      2'd1: begin
        w_rd_data[0] = r_run;
        w_rd_data[1] = r_irq_en;
        w_rd_data[8] = r_wrap;
      end
      2'd2: w_rd_data[PRE_W-1:0] = r_prescale;
      default: w_rd_data = '0;
    endcase
  end

  always_comb begin
    w_sel_mask = '0;
    for (int unsigned i = 0; i < 4; i++) w_sel_mask[i*8 +: 8] = {8{wbs_sel_i[i]}};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state   <= IDLE;
      r_last_la <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_wb)      r_last_la <= 1'b0;
      else if (w_grant_la) r_last_la <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_grant_wb)      w_state_nxt = WB_DONE;
        else if (w_grant_la) w_state_nxt = LA_DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ack_nxt     = w_grant_wb;
    w_la_ack_nxt  = w_grant_la;
    w_dat_nxt     = (w_grant_wb & ~wbs_we_i) ? w_rd_data : '0;
    w_load_nxt    = w_grant_la | w_wr_count;
    w_ld_data_nxt = '0;
    w_ld_mask_nxt = '0;
    if (w_grant_la) begin
      w_ld_data_nxt = la_data_i;
      w_ld_mask_nxt = la_mask_i;
    end else if (w_wr_count) begin
      w_ld_data_nxt = wbs_dat_i;
      w_ld_mask_nxt = w_sel_mask;
    end
  end

  // A tick colliding with a load is dropped, but the prescaler still wraps.
  assign w_tick     = r_run & (r_pcnt == r_prescale);
  assign w_wrap_set = cnt_en_o & (&cnt_value_i);
  assign w_wrap_clr = w_wr_ctrl & wbs_dat_i[8];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o       <= 1'b0;
      wbs_dat_o       <= '0;
      la_ack_o        <= 1'b0;
      cnt_load_o      <= 1'b0;
      cnt_load_data_o <= '0;
      cnt_load_mask_o <= '0;
      cnt_en_o        <= 1'b0;
      r_run           <= 1'b0;
      r_irq_en        <= 1'b0;
      r_wrap          <= 1'b0;
      r_prescale      <= '0;
      r_pcnt          <= '0;
    end else begin
      wbs_ack_o       <= w_ack_nxt;
      wbs_dat_o       <= w_dat_nxt;
      la_ack_o        <= w_la_ack_nxt;
      cnt_load_o      <= w_load_nxt;
      cnt_load_data_o <= w_ld_data_nxt;
      cnt_load_mask_o <= w_ld_mask_nxt;
      cnt_en_o        <= w_tick & ~w_load_nxt;
      if (w_wr_ctrl) begin
        r_run    <= wbs_dat_i[0];
        r_irq_en <= wbs_dat_i[1];
      end
      if (w_wr_pre) r_prescale <= wbs_dat_i[PRE_W-1:0];
      if (w_wr_pre | w_wr_ctrl | ~r_run | w_tick) r_pcnt <= '0;
      else                                        r_pcnt <= r_pcnt + PRE_W'(1);
      r_wrap <= w_wrap_set | (r_wrap & ~w_wrap_clr);
    end
  end

  assign irq_o = r_wrap & r_irq_en;

endmodule

// File: tb/tb_counter_access_ctrl.sv
// Scoreboard bench for counter_access_ctrl: expected acks/loads are queued when
// requests are driven and compared when the DUT presents them.
module tb_counter_access_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        la_req_i;
  logic [31:0] la_data_i, la_mask_i;
  logic        la_ack_o;
  logic [31:0] cnt_value_i;
  logic        cnt_load_o;
  logic [31:0] cnt_load_data_o, cnt_load_mask_o;
  logic        cnt_en_o, irq_o;

  counter_access_ctrl #(.BITS(32), .ADDR_BASE(28'h3000000), .PRE_W(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .la_req_i(la_req_i), .la_data_i(la_data_i), .la_mask_i(la_mask_i), .la_ack_o(la_ack_o),
    .cnt_value_i(cnt_value_i), .cnt_load_o(cnt_load_o),
    .cnt_load_data_o(cnt_load_data_o), .cnt_load_mask_o(cnt_load_mask_o),
    .cnt_en_o(cnt_en_o), .irq_o(irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  localparam logic [31:0] A_COUNT = 32'h3000_0000;
  localparam logic [31:0] A_CTRL  = 32'h3000_0004;
  localparam logic [31:0] A_PRE   = 32'h3000_0008;
  localparam logic [31:0] A_R3    = 32'h3000_000C;
  localparam logic [31:0] A_MISS  = 32'h3000_0010;

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    logic        la;
  } ld_t;

  logic [31:0] q_wb[$];
  ld_t         q_ld[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc_n = 0;

  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents an ack or a load.
  always @(negedge wb_clk_i) begin
    logic [31:0] e_dat;
    ld_t         e_ld;
    if (wbs_ack_o | la_ack_o) check_eq("ack_exclusive", 32'(wbs_ack_o & la_ack_o), 32'h0);
    if (la_ack_o) check_eq("la_ack_has_load", 32'(cnt_load_o), 32'h1);
    if (wbs_ack_o) begin
      if (q_wb.size() == 0) check_eq("wb_unexpected_ack", 32'(wbs_ack_o), 32'h0);
      else begin
        e_dat = q_wb.pop_front();
        check_eq("wb_rdata", wbs_dat_o, e_dat);
      end
    end
    if (cnt_load_o) begin
      if (q_ld.size() == 0) check_eq("unexpected_load", 32'(cnt_load_o), 32'h0);
      else begin
        e_ld = q_ld.pop_front();
        check_eq("load_data", cnt_load_data_o, e_ld.data);
        check_eq("load_mask", cnt_load_mask_o, e_ld.mask);
        check_eq("load_src_la", 32'(la_ack_o), 32'(e_ld.la));
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] exp_rd,
                         input int exp_lat, input int hold, output int ack_cyc);
    ld_t e;
    int  n;
    q_wb.push_back(we ? 32'h0 : exp_rd);
    if (we && adr[3:2] == 2'd0) begin
      e.data = dat;
      for (int i = 0; i < 4; i++) e.mask[i*8 +: 8] = {8{sel[i]}};
      e.la = 1'b0;
      q_ld.push_back(e);
    end
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    n = 0;
    do begin
      wait_cyc(1);
      n++;
    end while (!wbs_ack_o && n < 20);
    if (!wbs_ack_o) check_eq("wb_ack_timeout", 32'(wbs_ack_o), 32'h1);
    else if (exp_lat > 0) check_eq("wb_latency", 32'(n), 32'(exp_lat));
    ack_cyc = cyc_n;
    if (hold > 0) wait_cyc(hold);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_rd(input logic [31:0] adr, input logic [31:0] exp_rd);
    int c;
    wb_xfer(1'b0, adr, 32'h0, 4'hF, exp_rd, 1, 0, c);
    wait_cyc(1);
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int c;
    wb_xfer(1'b1, adr, dat, sel, 32'h0, 1, 0, c);
    wait_cyc(1);
  endtask

  task automatic la_load(input logic [31:0] dat, input logic [31:0] msk, output int ack_cyc);
    ld_t e;
    int  n;
    e.data = dat; e.mask = msk; e.la = 1'b1;
    q_ld.push_back(e);
    la_req_i = 1'b1; la_data_i = dat; la_mask_i = msk;
    n = 0;
    do begin
      wait_cyc(1);
      n++;
    end while (!la_ack_o && n < 20);
    if (!la_ack_o) check_eq("la_ack_timeout", 32'(la_ack_o), 32'h1);
    ack_cyc = cyc_n;
    la_req_i = 1'b0;
  endtask

  task automatic outputs_zero(input string tag);
    check_eq({tag, "_pulses"}, {27'b0, wbs_ack_o, la_ack_o, cnt_load_o, cnt_en_o, irq_o}, 32'h0);
    check_eq({tag, "_rdata"}, wbs_dat_o, 32'h0);
    check_eq({tag, "_ld_data"}, cnt_load_data_o, 32'h0);
    check_eq({tag, "_ld_mask"}, cnt_load_mask_o, 32'h0);
  endtask

  // Simultaneous WB and LA requests: WB first, then LA, then the re-issued WB read.
  task automatic tie_test(input logic [31:0] exp_ctrl);
    int c1, c2, c3;
    fork
      begin
        wb_xfer(1'b0, A_CTRL, 32'h0, 4'hF, exp_ctrl, 1, 0, c1);
        wb_xfer(1'b0, A_PRE, 32'h0, 4'hF, 32'h0, 0, 0, c3);
      end
      la_load(32'hDEAD_BEEF, 32'h0F0F_0F0F, c2);
    join
    check_eq("tie_la_after_wb", 32'(c2 - c1), 32'd2);
    check_eq("tie_wb_after_la", 32'(c3 - c2), 32'd2);
    wait_cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] en_seq;
    int          c, n_ack;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = '0;
    wbs_adr_i = '0;   wbs_dat_i = '0;   la_req_i = 1'b0;
    la_data_i = '0;   la_mask_i = '0;   cnt_value_i = '0;

    wait_cyc(3);
    outputs_zero("reset");
    wb_rst_ni = 1'b1;
    wait_cyc(1);

    tie_test(32'h0);
    wb_rd(A_CTRL, 32'h0);
    wb_rd(A_PRE, 32'h0);
    cnt_value_i = 32'h1234_5678;
    wb_rd(A_COUNT, 32'h1234_5678);
    wb_rd(A_R3, 32'h0);
    wb_wr(A_R3, 32'hFFFF_FFFF, 4'hF);
    wb_rd(A_PRE, 32'h0);

    // COUNT write with stb held one extra cycle past the ack
    wb_xfer(1'b1, A_COUNT, 32'hA5A5_A5A5, 4'b0101, 32'h0, 1, 1, c);
    wait_cyc(1);

    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = A_MISS;
    n_ack = 0;
    repeat (4) begin
      wait_cyc(1);
      if (wbs_ack_o) n_ack++;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check_eq("miss_no_ack", 32'(n_ack), 32'h0);
    wait_cyc(1);

    wb_wr(A_PRE, 32'd3, 4'h1);
    wb_rd(A_PRE, 32'd3);
    wb_xfer(1'b1, A_CTRL, 32'h1, 4'hF, 32'h0, 1, 0, c);
    en_seq = '0;
    for (int k = 0; k < 13; k++) begin
      en_seq[k] = cnt_en_o;
      if (k < 12) wait_cyc(1);
    end
    check_eq("pre3_ticks", en_seq, 32'h0000_1110);
    wait_cyc(3);
    la_load(32'h0000_0055, 32'h0000_00FF, c);
    en_seq = '0;
    for (int k = 0; k < 5; k++) begin
      en_seq[k] = cnt_en_o;
      if (k < 4) wait_cyc(1);
    end
    check_eq("tick_vs_load", en_seq, 32'h0000_0010);
    wait_cyc(1);

    wb_xfer(1'b1, A_PRE, 32'h0, 4'hF, 32'h0, 1, 0, c);
    en_seq = '0;
    for (int k = 0; k < 4; k++) begin
      wait_cyc(1);
      en_seq[k] = cnt_en_o;
    end
    check_eq("pre0_every_cycle", en_seq, 32'h0000_000F);
    wait_cyc(1);

    cnt_value_i = 32'hFFFF_FFFF;
    wait_cyc(2);
    wb_wr(A_CTRL, 32'h3, 4'hF);
    wb_rd(A_CTRL, 32'h103);
    check_eq("irq_set", 32'(irq_o), 32'h1);
    wb_xfer(1'b1, A_CTRL, 32'h103, 4'hF, 32'h0, 1, 0, c);
    check_eq("w1c_set_wins", 32'(irq_o), 32'h1);
    wait_cyc(1);
    wb_rd(A_CTRL, 32'h103);
    cnt_value_i = 32'h0;
    wait_cyc(2);
    wb_xfer(1'b1, A_CTRL, 32'h103, 4'hF, 32'h0, 1, 0, c);
    check_eq("w1c_clears", 32'(irq_o), 32'h0);
    wait_cyc(1);
    wb_rd(A_CTRL, 32'h003);

    cnt_value_i = 32'hFFFF_FFFF;
    wait_cyc(2);
    check_eq("irq_pre_reset", 32'(irq_o), 32'h1);
    la_load(32'h0000_1234, 32'h0000_FFFF, c);
    #5;
    wb_rst_ni = 1'b0;
    #1;
    outputs_zero("async_reset");
    cnt_value_i = 32'h0;
    wait_cyc(2);
    wb_rst_ni = 1'b1;
    wait_cyc(1);
    tie_test(32'h0);
    wb_rd(A_PRE, 32'h0);

    wait_cyc(3);
    check_eq("wb_queue_drained", 32'(q_wb.size()), 32'h0);
    check_eq("load_queue_drained", 32'(q_ld.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
